// File: rtl/mem_bus_arbiter_pkg.sv
// mem_bus_arbiter_pkg: shared FSM encodings and grant codes for the memory port arbiter
package mem_bus_arbiter_pkg;
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    I_ADDR = 3'd1,
    I_DATA = 3'd2,
    D_ADDR = 3'd3,
    D_DATA = 3'd4
  } state_t;
  typedef enum logic {GNT_INST = 1'b0, GNT_DATA = 1'b1} grant_t;
endpackage

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: round-robin sharing of one SRAM-like port between fetch and load/store
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                inst_req,
  input  logic [ADDR_W-1:0]   inst_addr,
  output logic [DATA_W-1:0]   inst_rdata,
  output logic                inst_valid,
  input  logic                data_req,
  input  logic [DATA_W/8-1:0] data_wen,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W-1:0]   data_wdata,
  output logic [DATA_W-1:0]   data_rdata,
  output logic                data_valid,
  output logic                bus_req,
  output logic                bus_wr,
  output logic [DATA_W/8-1:0] bus_wstrb,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic [DATA_W-1:0]   bus_wdata,
  input  logic                bus_addr_ok,
  input  logic                bus_data_ok,
  input  logic [DATA_W-1:0]   bus_rdata,
  output logic                stallreq_for_if,
  output logic                stallreq_for_mem
);
  state_t state;
  grant_t last_grant;
  logic   pick_data;
  // data wins when alone, or on a tie when fetch was served last
  assign pick_data = data_req & (~inst_req | (last_grant == GNT_INST));
  always_ff @(posedge clk)
    if (rst) begin
      state      <= IDLE;
      last_grant <= GNT_INST;
      bus_req    <= 1'b0;
      bus_wr     <= 1'b0;
      bus_wstrb  <= '0;
      bus_addr   <= '0;
      bus_wdata  <= '0;
    end else
      case (state)
        IDLE:
          if (pick_data) begin
            state     <= D_ADDR;
            bus_req   <= 1'b1;
            bus_wr    <= |data_wen;
            bus_wstrb <= data_wen;
            bus_addr  <= data_addr;
            bus_wdata <= data_wdata;
          end else if (inst_req) begin
            state     <= I_ADDR;
            bus_req   <= 1'b1;
            bus_wr    <= 1'b0;
            bus_wstrb <= '0;
            bus_addr  <= inst_addr;
            bus_wdata <= '0;
          end
        I_ADDR:
          if (bus_addr_ok) begin
            state   <= I_DATA;
            bus_req <= 1'b0;
          end
        I_DATA:
          if (bus_data_ok) begin
            state      <= IDLE;
            last_grant <= GNT_INST;
          end
        D_ADDR:
          if (bus_addr_ok) begin
            state   <= D_DATA;
            bus_req <= 1'b0;
          end
        D_DATA:
          if (bus_data_ok) begin
            state      <= IDLE;
            last_grant <= GNT_DATA;
          end
        default: begin
          state   <= IDLE;
          bus_req <= 1'b0;
        end
      endcase
  // completions are combinational on data_ok; a reset cycle suppresses them
  assign inst_valid       = ~rst & (state == I_DATA) & bus_data_ok;
  assign data_valid       = ~rst & (state == D_DATA) & bus_data_ok;
  assign inst_rdata       = inst_valid ? bus_rdata : '0;
  assign data_rdata       = data_valid ? bus_rdata : '0;
  assign stallreq_for_if  = ~rst & inst_req & ~inst_valid;
  assign stallreq_for_mem = ~rst & data_req & ~data_valid;
endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Shares the single SRAM-like memory port between the instruction-fetch requester and the data (MEM-stage) requester of the 5-stage pipeline. One transaction is outstanding at a time, chosen by round-robin arbitration. The block raises per-requester stall requests that the stall controller folds into the pipeline `StallBus`. It sits between the IF/MEM stages and the external memory interface.

## Interface
- `ADDR_W`, 32, address width.
- `DATA_W`, 32, data width; `DATA_W/8` byte strobes.
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `inst_req`  in  1  fetch request; held until `inst_valid`.
- `inst_addr`  in  ADDR_W  fetch address.
- `inst_rdata`  out  DATA_W  fetch data; valid with `inst_valid`.
- `inst_valid`  out  1  one-cycle fetch completion.
- `data_req`  in  1  load/store request; held until `data_valid`.
- `data_wen`  in  DATA_W/8  byte write enables; 0 = load.
- `data_addr`  in  ADDR_W  load/store address.
- `data_wdata`  in  DATA_W  store data.
- `data_rdata`  out  DATA_W  load data; valid with `data_valid`.
- `data_valid`  out  1  one-cycle load/store completion.
- `bus_req`  out  1  address-phase request.
- `bus_wr`  out  1  1 = write.
- `bus_wstrb`  out  DATA_W/8  byte strobes.
- `bus_addr`  out  ADDR_W  bus address.
- `bus_wdata`  out  DATA_W  bus write data.
- `bus_addr_ok`  in  1  address phase accepted.
- `bus_data_ok`  in  1  data phase complete.
- `bus_rdata`  in  DATA_W  read data; valid with `bus_data_ok`.
- `stallreq_for_if`  out  1  fetch pending, not completing this cycle.
- `stallreq_for_mem`  out  1  data access pending, not completing this cycle.

## Operation
- FSM states: IDLE, I_ADDR, I_DATA, D_ADDR, D_DATA.
- **IDLE**
  - Only `data_req`: go to D_ADDR.
  - Only `inst_req`: go to I_ADDR.
  - Both: grant the requester not served last (`last_grant` register). Reset value INST, so data wins the first tie.
  - On grant, latch addr, wen, wdata and `bus_wr = |wen` (inst: wr=0, wstrb=0) into request registers.
- **X_ADDR**
  - `bus_req`=1; bus_* driven from the latched registers, held stable.
  - On `bus_addr_ok`, go to X_DATA.
- **X_DATA**
  - `bus_req`=0.
  - On `bus_data_ok`: `X_valid`=1 and `X_rdata=bus_rdata` combinationally that cycle; `last_grant`<=X; go to IDLE.
- `bus_data_ok` is ignored outside X_DATA. `bus_addr_ok` is ignored outside X_ADDR.
- Writes also complete on `bus_data_ok`. `data_rdata` is don't-care for stores.
- No aborts: a request arriving during another transaction waits.
- Stall outputs:
  - `stallreq_for_if = inst_req & ~inst_valid`.
  - `stallreq_for_mem = data_req & ~data_valid`.
  - The stall controller maps `stallreq_for_mem` above `stallreq_for_if` in priority.
- Requester rule: req/addr/wen/wdata stay stable while the matching stall is high. A still-high req in IDLE after completion is treated as a new request.

## Timing
- Reset (`rst` sampled high):
  - State=IDLE, `last_grant`=INST, request registers=0.
  - All outputs 0: `bus_req`, `bus_wr`, `bus_wstrb`, `bus_addr`, `bus_wdata`, `inst_valid`, `data_valid`.
  - `inst_rdata`, `data_rdata` driven 0 when not valid.
  - Stall outputs are 0 during reset.
- Reset mid-transaction: drop to IDLE immediately; no completion pulse. The bus slave shares `rst`.
- Minimum latency, request to valid, is 3 cycles:
  - cycle 0: IDLE grant.
  - cycle 1: ADDR with `addr_ok`.
  - cycle 2: DATA with `data_ok`.
- Back-to-back transactions: 3 cycles each, since IDLE costs one cycle between them.
- Wait states: `bus_addr_ok` and `bus_data_ok` may be delayed arbitrarily. The FSM holds its state, and the stall outputs stay high.
- Valid pulses are exactly one cycle and never assert together.

## Structure
- Shared package / `lib/defines.vh`:
  - FSM state encodings (3-bit).
  - Grant codes INST/DATA.
  - Existing `StallBus` width.
- Single module. A separate `rr_pick2` sub-module is optional; a two-requester tie-break is small enough to inline.

## Test plan
- Reset, then `inst_req`=1 at addr 0xBFC00000 with `addr_ok`/`data_ok` immediate:
  - `bus_req` high in cycle 1 with that address, `bus_wr`=0.
  - `inst_valid`=1 in cycle 2, `inst_rdata` = `bus_rdata` (0x24080001).
  - `stallreq_for_if` high in cycles 0–1, low in cycle 2.
- `inst_req` and `data_req` (load, 0x80000010) rise in the same cycle after reset:
  - Data served first.
  - Then inst, starting the cycle after `data_valid`.
  - `stallreq_for_if` stays high throughout.
- Store with `data_wen`=4'b0011, wdata 0x0000BEEF:
  - `bus_wr`=1, `bus_wstrb`=0011, `bus_wdata` held stable across 4 cycles of `addr_ok`=0.
  - `data_valid` pulses on `data_ok`.
- `data_req` asserted while I_DATA waits 5 cycles for `data_ok`:
  - Inst completes unaborted.
  - Data granted in the next IDLE.
  - No `bus_req` during I_DATA.
- `rst` asserted in D_DATA:
  - Next cycle state=IDLE, all outputs 0, no `data_valid`.
  - A late `bus_data_ok` in IDLE is ignored.
- Both requesters continuously high for 6 transactions: grants alternate DATA, INST, DATA, INST, DATA, INST.
